// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared types, peripheral map constants and decode helper for the APB arbiter
package apb_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_DONE   = 3'd4
    } apb_arb_state_e;

    localparam logic [31:0] APB_BASE      = 32'h1000_0000;
    localparam logic [31:0] APB_SLOT_SIZE = 32'h0000_1000;
    localparam int          APB_NUM_SLOTS = 5;
    localparam logic [31:0] APB_LIMIT     = APB_BASE + APB_SLOT_SIZE * 32'(APB_NUM_SLOTS);

    // Anything outside the slot window is refused before it reaches the bus.
    function automatic logic addr_in_map(input logic [31:0] addr);
        return (addr >= APB_BASE) && (addr < APB_LIMIT);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker: first valid index at or after ptr, wrapping
module rr_arbiter #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic found;

    // Two passes: indices at or above ptr first, then the wrapped-around low indices.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (IW'(j) >= ptr)) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin sequencer sharing one APB master request port among NUM_REQ requesters
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_write,
    input  logic [NUM_REQ-1:0][31:0] req_addr,
    input  logic [NUM_REQ-1:0][31:0] req_wdata,
    output logic [NUM_REQ-1:0]       req_done,
    output logic [NUM_REQ-1:0]       req_err,
    output logic [31:0]              req_rdata,
    output logic [IDW-1:0]           grant_id,
    output logic                     busy,
    output logic                     transfer,
    output logic                     write,
    output logic [31:0]              addr,
    output logic [31:0]              wdata,
    input  logic                     ready,
    input  logic [31:0]              rdata
);

    apb_arb_state_e     state;
    apb_arb_state_e     state_next;
    logic [IDW-1:0]     rr_ptr;
    logic               err_flag;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDW-1:0]     arb_idx;
    logic               arb_any;
    logic               win_in_map;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign arb_any    = |arb_gnt;
    assign win_in_map = addr_in_map(req_addr[arb_idx]);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (arb_any) begin
                    state_next = win_in_map ? ST_ISSUE : ST_DONE;
                end
            end
            ST_ISSUE:  state_next = ST_SETUP;
            // A slave may raise ready early; only ACCESS looks at it.
            ST_SETUP:  state_next = ST_ACCESS;
            ST_ACCESS: begin
                if (ready) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        transfer = 1'b0;
        busy     = 1'b1;
        req_done = '0;
        req_err  = '0;
        unique case (state)
            ST_IDLE:  busy = 1'b0;
            ST_ISSUE: transfer = 1'b1;
            ST_DONE: begin
                if (err_flag) begin
                    req_err[grant_id] = 1'b1;
                end else begin
                    req_done[grant_id] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Request fields are latched at grant so the master sees them stable for the whole transaction.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rr_ptr    <= '0;
            err_flag  <= 1'b0;
            grant_id  <= '0;
            write     <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            req_rdata <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        grant_id <= arb_idx;
                        write    <= req_write[arb_idx];
                        addr     <= req_addr[arb_idx];
                        wdata    <= req_wdata[arb_idx];
                        err_flag <= !win_in_map;
                    end
                end
                ST_ACCESS: begin
                    if (ready && !write) begin
                        req_rdata <= rdata;
                    end
                end
                ST_DONE: begin
                    rr_ptr   <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                    err_flag <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - scoreboard bench for apb_master_arbiter with a behavioural APB slave
module tb_apb_master_arbiter;

    localparam int NR = 2;

    logic                PCLK = 1'b0;
    logic                PRESET;
    logic [NR-1:0]       req_valid;
    logic [NR-1:0]       req_write;
    logic [NR-1:0][31:0] req_addr;
    logic [NR-1:0][31:0] req_wdata;
    logic [NR-1:0]       req_done;
    logic [NR-1:0]       req_err;
    logic [31:0]         req_rdata;
    logic [0:0]          grant_id;
    logic                busy;
    logic                transfer;
    logic                write;
    logic [31:0]         addr;
    logic [31:0]         wdata;
    logic                ready;
    logic [31:0]         rdata;

    apb_master_arbiter #(
        .NUM_REQ (NR)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_done  (req_done),
        .req_err   (req_err),
        .req_rdata (req_rdata),
        .grant_id  (grant_id),
        .busy      (busy),
        .transfer  (transfer),
        .write     (write),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .rdata     (rdata)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int          idx;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          cfg_waits = 0;
    bit          cfg_early = 0;
    logic [31:0] rd_word;
    int          phase = 0;
    int          wl = 0;
    int          xfer_cnt = 0;
    int          last_xfer = -1;
    int          reissue[NR];
    int          c;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_req(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d,
                             input bit err, input logic [31:0] exp_rd, input int exp_cyc);
        exp_t e;
        req_valid[i] = 1'b1;
        req_write[i] = wr;
        req_addr[i]  = a;
        req_wdata[i] = d;
        e.idx = i; e.wr = wr; e.addr = a; e.wdata = d;
        e.err = err; e.rdata = exp_rd; e.cyc = exp_cyc;
        sb.push_back(e);
    endtask

    task automatic hold_checks();
        if (sb.size() > 0) begin
            chk("hold_addr", addr, sb[0].addr);
            chk("hold_write", 32'(write), 32'(sb[0].wr));
            if (sb[0].wr) chk("hold_wdata", wdata, sb[0].wdata);
        end
    endtask

    task automatic slave_step();
        if (transfer) begin
            xfer_cnt++;
            last_xfer = cyc;
            phase = 1;
            wl = cfg_waits;
            ready = 1'b0;
            rdata = '0;
            if (sb.size() > 0) begin
                chk("xfer_gid", 32'(grant_id), 32'(sb[0].idx));
                chk("xfer_addr", addr, sb[0].addr);
                chk("xfer_write", 32'(write), 32'(sb[0].wr));
                if (sb[0].wr) chk("xfer_wdata", wdata, sb[0].wdata);
            end
        end else if (phase == 1) begin
            hold_checks();
            phase = 2;
            ready = cfg_early;
            rdata = 32'hBAD0_0000;
        end else if (phase == 2) begin
            hold_checks();
            if (wl == 0) begin
                ready = 1'b1;
                rdata = rd_word;
                phase = 0;
            end else begin
                wl--;
                ready = 1'b0;
            end
        end else begin
            ready = 1'b0;
            rdata = '0;
        end
    endtask

    task automatic mon_step();
        logic [NR-1:0] p;
        int id;
        exp_t e;
        p = req_done | req_err;
        if (p != '0) begin
            chk("pulse_onehot", 32'($countones(p)), 32'd1);
            chk("done_err_excl", 32'(req_done & req_err), 32'd0);
            id = 0;
            for (int i = 0; i < NR; i++) if (p[i]) id = i;
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 32'(p), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("grant_idx", 32'(id), 32'(e.idx));
                chk("is_err", 32'(req_err[id]), 32'(e.err));
                if (!e.err) chk("req_rdata", req_rdata, e.rdata);
                if (e.cyc >= 0) chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
            req_valid[id] = 1'b0;
            if (reissue[id] > 0) begin
                reissue[id]--;
                if (id == 0) drive_req(0, 1'b0, 32'h1000_0040, 32'h0, 1'b0, rd_word, -1);
                else         drive_req(1, 1'b1, 32'h1000_2000, 32'hC0DE_0002, 1'b0, rd_word, -1);
            end
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
        cyc++;
        slave_step();
        mon_step();
    endtask

    task automatic run(input int budget);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            step();
            n++;
        end
        if (sb.size() > 0) begin
            chk("timeout_pending", 32'(sb.size()), 32'd0);
            sb.delete();
            phase = 0;
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
        chk({pfx, "_transfer"}, 32'(transfer), 32'd0);
        chk({pfx, "_req_done"}, 32'(req_done), 32'd0);
        chk({pfx, "_req_err"}, 32'(req_err), 32'd0);
        chk({pfx, "_grant_id"}, 32'(grant_id), 32'd0);
        chk({pfx, "_write"}, 32'(write), 32'd0);
        chk({pfx, "_addr"}, addr, 32'd0);
        chk({pfx, "_wdata"}, wdata, 32'd0);
        chk({pfx, "_req_rdata"}, req_rdata, 32'd0);
    endtask

    task automatic do_reset();
        PRESET = 1'b1;
        req_valid = '0;
        phase = 0;
        ready = 1'b0;
        step();
        PRESET = 1'b0;
    endtask

    initial begin
        PRESET = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        ready = 1'b0; rdata = '0; rd_word = '0;
        for (int i = 0; i < NR; i++) reissue[i] = 0;
        repeat (2) step();
        chk_zero("reset");
        PRESET = 1'b0;
        step();

        // single zero-wait read
        rd_word = 32'hDEAD_BEEF; cfg_waits = 0; xfer_cnt = 0; c = cyc;
        drive_req(0, 1'b0, 32'h1000_1004, 32'h0, 1'b0, 32'hDEAD_BEEF, c + 4);
        run(40);
        chk("rd_xfer_cnt", 32'(xfer_cnt), 32'd1);
        chk("rd_xfer_cycle", 32'(last_xfer), 32'(c + 1));
        step();
        chk("rd_idle_busy", 32'(busy), 32'd0);

        // write with three wait states; slave data must not reach req_rdata
        rd_word = 32'h1111_2222; cfg_waits = 3; xfer_cnt = 0; c = cyc;
        drive_req(1, 1'b1, 32'h1000_3000, 32'hA5A5_0001, 1'b0, 32'hDEAD_BEEF, c + 7);
        run(40);
        chk("wr_xfer_cnt", 32'(xfer_cnt), 32'd1);
        step();
        chk("wr_idle_busy", 32'(busy), 32'd0);
        chk("wr_rdata_kept", req_rdata, 32'hDEAD_BEEF);

        // first address past the map
        cfg_waits = 0; xfer_cnt = 0; c = cyc;
        drive_req(0, 1'b0, 32'h1000_5000, 32'h0, 1'b1, 32'h0, c + 1);
        run(20);
        step();
        chk("unmap_busy_c2", 32'(busy), 32'd0);
        chk("unmap_cycle", 32'(cyc), 32'(c + 2));
        chk("unmap_xfer_cnt", 32'(xfer_cnt), 32'd0);

        // last word of the map
        rd_word = 32'h0BAD_F00D; c = cyc;
        drive_req(1, 1'b0, 32'h1000_4FFC, 32'h0, 1'b0, 32'h0BAD_F00D, c + 4);
        run(40);
        step();

        // just below the map
        xfer_cnt = 0; c = cyc;
        drive_req(0, 1'b0, 32'h0FFF_FFFC, 32'h0, 1'b1, 32'h0, c + 1);
        run(20);
        step();
        chk("below_xfer_cnt", 32'(xfer_cnt), 32'd0);

        // contention from a fresh pointer
        do_reset();
        rd_word = 32'h1234_5678; cfg_waits = 0; xfer_cnt = 0;
        reissue[0] = 1; reissue[1] = 1;
        drive_req(0, 1'b0, 32'h1000_0010, 32'h0, 1'b0, rd_word, -1);
        drive_req(1, 1'b1, 32'h1000_2004, 32'hC0DE_0001, 1'b0, rd_word, -1);
        run(100);
        chk("cont_xfer_cnt", 32'(xfer_cnt), 32'd4);
        step();
        chk("cont_idle_busy", 32'(busy), 32'd0);

        // slave raises ready during SETUP
        rd_word = 32'h0F0F_0F0F; cfg_early = 1'b1; xfer_cnt = 0; c = cyc;
        drive_req(0, 1'b0, 32'h1000_0008, 32'h0, 1'b0, 32'h0F0F_0F0F, c + 4);
        run(40);
        chk("early_xfer_cnt", 32'(xfer_cnt), 32'd1);
        cfg_early = 1'b0;
        step();

        // reset while waiting in ACCESS; pointer must return to 0
        rd_word = 32'h7777_0001; cfg_waits = 5; c = cyc;
        drive_req(1, 1'b0, 32'h1000_0100, 32'h0, 1'b0, rd_word, -1);
        repeat (4) step();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_gid", 32'(grant_id), 32'd1);
        PRESET = 1'b1;
        sb.delete();
        phase = 0; ready = 1'b0;
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h1000_0200;
        step();
        chk_zero("abort");
        PRESET = 1'b0; cfg_waits = 0; c = cyc;
        drive_req(0, 1'b0, 32'h1000_0200, 32'h0, 1'b0, rd_word, c + 4);
        drive_req(1, 1'b0, 32'h1000_0100, 32'h0, 1'b0, rd_word, -1);
        run(60);
        step();
        chk("post_rst_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Round-robin arbiter and sequencer that shares the single APB master's internal request port (transfer/ready/write/addr/wdata/rdata) among NUM_REQ on-chip requesters (CPU load/store unit, DMA, debug). It sits directly in front of the APB master. It owns one transaction at a time, enforces the master's IDLE/SETUP/ACCESS timing, and rejects addresses outside the five-slot peripheral map without issuing them, so an unmapped address never stalls the bus.

## Interface
- NUM_REQ, 2: number of requesters, 2..8.
- PCLK  input  1  clock.
- PRESET  input  1  reset; synchronous, active-high.
- req_valid  input  [NUM_REQ]  request pending; held with its fields until req_done/req_err for that index.
- req_write  input  [NUM_REQ]  1 = write, 0 = read.
- req_addr  input  [NUM_REQ][32]  byte address.
- req_wdata  input  [NUM_REQ][32]  write data.
- req_done  output  [NUM_REQ]  one-cycle completion pulse, one-hot or zero.
- req_err  output  [NUM_REQ]  one-cycle decode-error pulse, one-hot or zero; never coincident with req_done.
- req_rdata  output  32  read data of the last completed read; shared by all requesters; qualified by req_done.
- grant_id  output  $clog2(NUM_REQ)  index of the owner; valid while busy.
- busy  output  1  transaction in flight.
- transfer  output  1  to master; single-cycle start.
- write, addr, wdata  output  1/32/32  to master; registered copies of the granted request.
- ready  input  1  from master; sampled only in ACCESS.
- rdata  input  32  from master; sampled only when ready is sampled high.

## Operation
- States: IDLE, ISSUE, SETUP, ACCESS, DONE.
- IDLE:
  - If any req_valid, the rr_arbiter picks the first valid index at or after rr_ptr, wrapping.
  - Register grant_id and the winner's write/addr/wdata.
  - If addr is in the map (0x1000_0000–0x1000_4FFF), go to ISSUE; otherwise go to DONE with err_flag set.
- ISSUE: transfer=1 for this cycle only; go to SETUP.
- SETUP: mirrors the master's SETUP cycle. ready is ignored here because a slave may drive it early. Go to ACCESS.
- ACCESS:
  - Wait on ready.
  - When ready=1, capture rdata (reads only; writes leave req_rdata unchanged) and go to DONE.
  - No timeout; the map check guarantees a responding slave.
- DONE:
  - Pulse req_done[grant_id], or req_err[grant_id] if err_flag is set.
  - rr_ptr <= grant_id+1, wrapping at NUM_REQ.
  - Go to IDLE.
- Requesters must drop or replace req_valid at the clock edge that samples their done/err pulse. IDLE re-arbitrates on the following cycle.
- Fairness: an owner cannot win twice in a row while another index is valid.
- busy=1 in every state except IDLE.

## Timing
- Reset values: all outputs 0, rr_ptr=0, state=IDLE, err_flag=0.
- Mapped access with a zero-wait slave, req_valid seen in IDLE at cycle 0:
  - ISSUE, transfer=1: cycle 1.
  - Master SETUP: cycle 2.
  - ACCESS, ready=1: cycle 3.
  - req_done: cycle 4.
  - Total 5 cycles request-to-next-IDLE.
  - Each slave wait state adds 1 cycle in ACCESS.
- Unmapped access: req_err in cycle 1 (IDLE→DONE); transfer never asserts.
- Simultaneous requests: grant order follows rr_ptr; a request arriving while busy waits for IDLE.
- A request that drops req_valid before grant is simply not selected. Dropping it after grant is illegal; the transaction still completes.
- Reset mid-transaction: the next edge forces IDLE, clears pulses and transfer, and sets rr_ptr=0. No done/err is issued for the aborted request. The master shares PRESET and resets in the same cycle.

## Structure
- Package apb_arb_pkg holds:
  - the state enum apb_arb_state_e;
  - APB_BASE = 32'h1000_0000;
  - APB_SLOT_SIZE = 32'h1000;
  - APB_NUM_SLOTS = 5;
  - function addr_in_map(addr).
- Sub-module rr_arbiter (parameter N): inputs req[N] and ptr; outputs a one-hot gnt and its index. Purely combinational; the FSM and pointer live in the parent.

## Test plan
- Single read: req0 reads 0x1000_1004, slave returns 0xDEAD_BEEF with 0 waits → transfer in cycle 1 only, req_done[0] in cycle 4, req_rdata=0xDEAD_BEEF.
- Write with 3 wait states: req1 writes 0xA5A5_0001 to 0x1000_3000 → addr/wdata/write stable from ISSUE through ACCESS, req_done[1] in cycle 7, req_rdata unchanged.
- Contention: req0 and req1 both valid continuously, rr_ptr=0 → grants 0,1,0,1; no index is granted twice in a row.
- Unmapped: req0 reads 0x1000_5000 → req_err[0] in cycle 1, transfer never 1, busy back to 0 in cycle 2.
- Early ready: slave holds ready=1 during SETUP → arbiter ignores it, done still in cycle 4, exactly one transaction issued.
- Reset in ACCESS: PRESET high for one cycle → next cycle all outputs 0, state IDLE; a new req0 after reset is granted first.
